hazard_ctrl_pipe: RTL

- Consumer end of the decode-stage control bundle (RegWriteD…RegDstD, ALUControlD).
- Carries that bundle and the register specifiers through the E, M and W stages of the 5-stage MIPS pipeline.
- Detects load-use and branch-operand hazards, then drives stall and flush.
- Generates the E-stage and D-stage forwarding selects, and keeps a saturating stall-cycle counter for performance checks.

---
 rtl/hazard_ctrl_pipe.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_pipe.sv
// Hazard control and E/M/W control pipeline for a 5-stage MIPS core.
// Ports: decoded D-stage controls and specifiers in; stall/flush, E- and D-stage
//   forwarding selects, registered E/M/W controls and a saturating stall counter out.
module hazard_ctrl_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             MemWriteD,
  input  logic             BranchD,
  input  logic             ALUSrcD,
  input  logic             ALUSrc_shamtD,
  input  logic             RegDstD,
  input  logic [3:0]       ALUControlD,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RdD,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             RegWriteE,
  output logic             MemtoRegE,
  output logic             MemWriteE,
  output logic             ALUSrcE,
  output logic             ALUSrc_shamtE,
  output logic             RegDstE,
  output logic [3:0]       ALUControlE,
  output logic [4:0]       RsE,
  output logic [4:0]       RtE,
  output logic [4:0]       RdE,
  output logic [4:0]       WriteRegE,
  output logic             RegWriteM,
  output logic             MemtoRegM,
  output logic             MemWriteM,
  output logic [4:0]       WriteRegM,
  output logic             RegWriteW,
  output logic             MemtoRegW,
  output logic [4:0]       WriteRegW,
  output logic [CNT_W-1:0] StallCount
);

  logic lwstall;
  logic branchstall;
  logic br_hit_e;
  logic br_hit_m;
  logic stall;

  assign WriteRegE = RegDstE ? RdE : RtE;

  // A load in E whose target is a D-stage source must wait one cycle for memory.
  assign lwstall = MemtoRegE && (RtE != 5'd0) && ((RtE == RsD) || (RtE == RtD));

  // The branch comparator sits in D, so an ALU result still in E, or a load
  // result still in M, cannot reach it in time.
  assign br_hit_e = RegWriteE && (WriteRegE != 5'd0) &&
                    ((WriteRegE == RsD) || (WriteRegE == RtD));
  assign br_hit_m = MemtoRegM && (WriteRegM != 5'd0) &&
                    ((WriteRegM == RsD) || (WriteRegM == RtD));
  assign branchstall = BranchD && (br_hit_e || br_hit_m);

  assign stall  = lwstall || branchstall;
  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;

  // E-stage operand selects; the younger result in M wins over W.
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RsE))
      ForwardAE = 2'b10;
    else if (RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RsE))
      ForwardAE = 2'b01;
  end

  always_comb begin
    ForwardBE = 2'b00;
    if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RtE))
      ForwardBE = 2'b10;
    else if (RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RtE))
      ForwardBE = 2'b01;
  end

  assign ForwardAD = RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RsD);
  assign ForwardBD = RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RtD);

  // E register: a flush loads a bubble instead of the held D bundle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteE     <= 1'b0;
      MemtoRegE     <= 1'b0;
      MemWriteE     <= 1'b0;
      ALUSrcE       <= 1'b0;
      ALUSrc_shamtE <= 1'b0;
      RegDstE       <= 1'b0;
      ALUControlE   <= 4'd0;
      RsE           <= 5'd0;
      RtE           <= 5'd0;
      RdE           <= 5'd0;
    end else if (FlushE) begin
      RegWriteE     <= 1'b0;
      MemtoRegE     <= 1'b0;
      MemWriteE     <= 1'b0;
      ALUSrcE       <= 1'b0;
      ALUSrc_shamtE <= 1'b0;
      RegDstE       <= 1'b0;
      ALUControlE   <= 4'd0;
      RsE           <= 5'd0;
      RtE           <= 5'd0;
      RdE           <= 5'd0;
    end else begin
      RegWriteE     <= RegWriteD;
      MemtoRegE     <= MemtoRegD;
      MemWriteE     <= MemWriteD;
      ALUSrcE       <= ALUSrcD;
      ALUSrc_shamtE <= ALUSrc_shamtD;
      RegDstE       <= RegDstD;
      ALUControlE   <= ALUControlD;
      RsE           <= RsD;
      RtE           <= RtD;
      RdE           <= RdD;
    end
  end

  // M and W always advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
      MemWriteM <= 1'b0;
      WriteRegM <= 5'd0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      WriteRegW <= 5'd0;
    end else begin
      RegWriteM <= RegWriteE;
      MemtoRegM <= MemtoRegE;
      MemWriteM <= MemWriteE;
      WriteRegM <= WriteRegE;
      RegWriteW <= RegWriteM;
      MemtoRegW <= MemtoRegM;
      WriteRegW <= WriteRegM;
    end
  end

  // Stall-cycle counter, sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      StallCount <= '0;
    else if (StallD && (StallCount != {CNT_W{1'b1}}))
      StallCount <= StallCount + CNT_W'(1);
  end

endmodule
